// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared names for the EX stage and the multi-cycle divider: FSM state
// encodings and the all-zero {HI, LO} result constant.
// -----------------------------------------------------------------------------
package div_unit_pkg;

  // Divider control states (encodings are visible to EX as well).
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // Result driven whenever no valid quotient/remainder is presented.
  localparam logic [63:0] DIV_RESULT_ZERO = 64'b0;

endpackage : div_unit_pkg

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
// Request/response bundle between EX (master) and div_unit (slave).
//   start_i    : divide request, held high until success_o is seen
//   signed_i   : 1 = DIV (two's complement), 0 = DIVU
//   dividend_i : rs operand
//   divider_i  : rt operand
//   annul_i    : flush/exception cancel of an in-flight divide
//   result_o   : {remainder, quotient} -> {HI, LO}
//   success_o  : result valid, held while start_i stays high
//   busy_o     : divider is iterating
// -----------------------------------------------------------------------------
interface div_unit_if #(
  parameter int WIDTH = 32
);

  logic                 start_i;
  logic                 signed_i;
  logic [WIDTH-1:0]     dividend_i;
  logic [WIDTH-1:0]     divider_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 success_o;
  logic                 busy_o;

  modport master (
    output start_i, signed_i, dividend_i, divider_i, annul_i,
    input  result_o, success_o, busy_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divider_i, annul_i,
    output result_o, success_o, busy_o
  );

endinterface : div_unit_if

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Operands are captured
// once (capture edge T0); WIDTH iterations follow, the last one writing the
// sign-corrected {remainder, quotient}. Divide by zero answers zero on the
// capture edge. Withdrawing start_i or raising annul_i returns to IDLE.
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : div_unit_if.slave (request operands in, result/status out)
// -----------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);

  localparam logic [2*WIDTH-1:0] RESULT_ZERO = (2*WIDTH)'(DIV_RESULT_ZERO);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   W_ZERO      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   W_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  // WIDTH-bit two's-complement negate (0x80..0 maps to itself).
  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    return (~v) + W_ONE;
  endfunction

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divider when it fits.
  // Returns {new_remainder[WIDTH:0], quotient_bit}.
  function automatic logic [WIDTH+1:0] div_step(input logic [WIDTH:0]   rem,
                                               input logic             msb,
                                               input logic [WIDTH-1:0] dvr);
    logic [WIDTH:0] trial;
    trial = {rem[WIDTH-1:0], msb};
    if (trial >= {1'b0, dvr}) begin
      return {trial - {1'b0, dvr}, 1'b1};
    end else begin
      return {trial, 1'b0};
    end
  endfunction

  div_state_e          state_r,   state_s;
  logic [WIDTH-1:0]    dvd_r,     dvd_s;
  logic [WIDTH-1:0]    dvr_r,     dvr_s;
  logic [WIDTH:0]      rem_r,     rem_s;
  logic [WIDTH-1:0]    quo_r,     quo_s;
  logic [CNT_W-1:0]    cnt_r,     cnt_s;
  logic                neg_q_r,   neg_q_s;
  logic                neg_r_r,   neg_r_s;
  logic [2*WIDTH-1:0]  result_r,  result_s;
  logic                success_r, success_s;
  logic                busy_r,    busy_s;

  logic [WIDTH-1:0]    abs_a_s;
  logic [WIDTH-1:0]    abs_b_s;
  logic [WIDTH+1:0]    step_s;
  logic [WIDTH-1:0]    quo_fin_s;
  logic [WIDTH-1:0]    rem_fin_s;
  logic                go_idle_s;

  // Magnitudes are only taken for signed requests with a negative operand.
  assign abs_a_s = (bus.signed_i && bus.dividend_i[WIDTH-1]) ? neg2c(bus.dividend_i) : bus.dividend_i;
  assign abs_b_s = (bus.signed_i && bus.divider_i[WIDTH-1])  ? neg2c(bus.divider_i)  : bus.divider_i;

  assign step_s    = div_step(rem_r, dvd_r[WIDTH-1], dvr_r);
  assign quo_fin_s = neg_q_r ? neg2c({quo_r[WIDTH-2:0], step_s[0]}) : {quo_r[WIDTH-2:0], step_s[0]};
  assign rem_fin_s = neg_r_r ? neg2c(step_s[WIDTH:1]) : step_s[WIDTH:1];

  // Cancel wins over everything; a dropped start_i outside IDLE is a withdrawal.
  assign go_idle_s = bus.annul_i || ((state_r != DIV_IDLE) && !bus.start_i);

  assign busy_s = (state_s == DIV_BUSY);

  // Next-state and next-datapath computation.
  always_comb begin
    state_s   = state_r;
    dvd_s     = dvd_r;
    dvr_s     = dvr_r;
    rem_s     = rem_r;
    quo_s     = quo_r;
    cnt_s     = cnt_r;
    neg_q_s   = neg_q_r;
    neg_r_s   = neg_r_r;
    result_s  = result_r;
    success_s = success_r;

    if (go_idle_s) begin
      state_s   = DIV_IDLE;
      dvd_s     = W_ZERO;
      dvr_s     = W_ZERO;
      rem_s     = {(WIDTH+1){1'b0}};
      quo_s     = W_ZERO;
      cnt_s     = {CNT_W{1'b0}};
      neg_q_s   = 1'b0;
      neg_r_s   = 1'b0;
      result_s  = RESULT_ZERO;
      success_s = 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          result_s  = RESULT_ZERO;
          success_s = 1'b0;
          if (bus.start_i) begin
            if (bus.divider_i == W_ZERO) begin
              state_s   = DIV_DONE;
              success_s = 1'b1;
            end else begin
              state_s = DIV_BUSY;
              dvd_s   = abs_a_s;
              dvr_s   = abs_b_s;
              rem_s   = {(WIDTH+1){1'b0}};
              quo_s   = W_ZERO;
              cnt_s   = {CNT_W{1'b0}};
              neg_q_s = bus.signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divider_i[WIDTH-1]);
              neg_r_s = bus.signed_i & bus.dividend_i[WIDTH-1];
            end
          end else begin
            state_s = DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          dvd_s = {dvd_r[WIDTH-2:0], 1'b0};
          rem_s = step_s[WIDTH+1:1];
          quo_s = {quo_r[WIDTH-2:0], step_s[0]};
          cnt_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_s   = DIV_DONE;
            result_s  = {rem_fin_s, quo_fin_s};
            success_s = 1'b1;
          end else begin
            state_s = DIV_BUSY;
          end
        end
        DIV_DONE: begin
          state_s = DIV_DONE;
        end
        default: begin
          state_s   = DIV_IDLE;
          result_s  = RESULT_ZERO;
          success_s = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= DIV_IDLE;
      dvd_r     <= W_ZERO;
      dvr_r     <= W_ZERO;
      rem_r     <= {(WIDTH+1){1'b0}};
      quo_r     <= W_ZERO;
      cnt_r     <= {CNT_W{1'b0}};
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      result_r  <= RESULT_ZERO;
      success_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      dvd_r     <= dvd_s;
      dvr_r     <= dvr_s;
      rem_r     <= rem_s;
      quo_r     <= quo_s;
      cnt_r     <= cnt_s;
      neg_q_r   <= neg_q_s;
      neg_r_r   <= neg_r_s;
      result_r  <= result_s;
      success_r <= success_s;
      busy_r    <= busy_s;
    end
  end

  assign bus.result_o  = result_r;
  assign bus.success_o = success_r;
  assign bus.busy_o    = busy_r;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Scoreboard bench for div_unit: the driver pushes the expected {HI, LO}
// result and the cycle at which success_o must first rise; an independent
// monitor pops and compares whenever success_o rises.
// -----------------------------------------------------------------------------
module tb_div_unit;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t exp_q[$];

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Reference: plain 64-bit arithmetic (truncating /, dividend-signed %).
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor / scoreboard.
  initial begin
    bit   prev_succ;
    exp_t e;
    prev_succ = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.success_o && !prev_succ) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_success: got success_o=1 result=%h, required no response", bus.result_o);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (bus.result_o !== e.res) begin
            errors++;
            $display("FAIL result: got %h, required %h", bus.result_o, e.res);
          end
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL latency: got cycle %0d, required cycle %0d", cyc, e.due);
          end
        end
      end
      if (bus.success_o) begin
        checks++;
        if (bus.busy_o !== 1'b0) begin
          errors++;
          $display("FAIL busy_with_success: got busy_o=%b, required 0", bus.busy_o);
        end
      end
      prev_succ = bus.success_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check1(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Called right after a negedge; returns right after the negedge that
  // follows the capture edge. Operands are scrambled afterwards.
  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divider_i  = b;
    bus.start_i    = 1'b1;
    if (push) begin
      e.res = ref_div(sgn, a, b);
      e.due = cyc + ((b == 32'd0) ? 1 : 33);
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (b != 32'd0) begin
      check1("busy_after_capture", {63'd0, bus.busy_o}, 64'd1);
    end
    bus.dividend_i = $urandom;
    bus.divider_i  = $urandom;
    bus.signed_i   = ~sgn;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.success_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.success_o) begin
      checks++; errors++;
      $display("FAIL timeout: got success_o=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic release_start();
    bus.start_i = 1'b0;
    @(negedge clk);
    check1("success_drop", {63'd0, bus.success_o}, 64'd0);
    check1("result_clear", bus.result_o, 64'd0);
  endtask

  task automatic full_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    issue(sgn, a, b, 1'b1);
    wait_done();
    release_start();
  endtask

  task automatic check_idle(input string name);
    check1({name, "_success"}, {63'd0, bus.success_o}, 64'd0);
    check1({name, "_busy"},    {63'd0, bus.busy_o},    64'd0);
    check1({name, "_result"},  bus.result_o,           64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd0;
    bus.divider_i  = 32'd0;
    bus.annul_i    = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);

    // Directed cases.
    full_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    full_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    full_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    full_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    full_div(1'b0, 32'h1234_5678, 32'd0);
    full_div(1'b1, 32'h8000_0000, 32'd0);
    full_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

    // Cancel at iteration 10, then a fresh request.
    issue(1'b0, 32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    check_idle("annul");
    bus.start_i = 1'b0;
    @(negedge clk);
    full_div(1'b1, 32'hDEAD_BEEF, 32'd3);

    // Annul overriding a simultaneous start in IDLE.
    bus.annul_i = 1'b1;
    issue(1'b0, 32'd100, 32'd0, 1'b0);
    bus.annul_i = 1'b0;
    check_idle("annul_vs_start");
    bus.start_i = 1'b0;
    @(negedge clk);

    // Withdrawn request mid-BUSY.
    issue(1'b0, 32'd1000, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    check_idle("withdraw");

    // Asynchronous reset mid-BUSY: outputs clear without a clock edge.
    issue(1'b1, 32'hF000_0001, 32'd5, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_idle("async_reset");
    bus.start_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Back-to-back with one idle edge between.
    full_div(1'b0, 32'd1000, 32'd33);
    full_div(1'b1, 32'hFFFF_FC18, 32'd33);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      full_div(1'($urandom_range(0, 1)), a, b);
    end

    repeat (2) @(negedge clk);
    check1("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_div_unit

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider serving the EX stage for DIV/DIVU.
- EX holds start_i high with the operands stable until success_o rises. EX then takes the {HI, LO} result, drops start_i, and releases its pipeline pause.
- Downstream, EX forwards the result as HI/LO write data. annul_i lets the exception/flush logic kill an in-flight divide.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH, laid out {remainder, quotient}.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- start_i  in  1  divide request; held high by EX until success_o is seen.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- dividend_i  in  WIDTH  rs operand.
- divider_i  in  WIDTH  rt operand.
- annul_i  in  1  flush/exception cancel; highest priority after reset.
- result_o  out  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
- success_o  out  1  result valid; held until start_i low.
- busy_o  out  1  high in BUSY state.

Behaviour:
- Reset (rst==0, async): state=IDLE; result_o=0, success_o=0, busy_o=0; counter and internal registers cleared.
- Internal registers:
  - |dividend| shift register, WIDTH.
  - |divider|, WIDTH.
  - partial remainder, WIDTH+1 bits.
  - quotient.
  - counter.
  - sign flags neg_q = sign(a)^sign(b) and neg_r = sign(a), computed only when signed_i=1.
- IDLE:
  - If start_i=1, annul_i=0 and divider_i==0: go to DONE next edge with result_o=0, success_o=1.
  - If start_i=1, annul_i=0 and divider_i!=0: latch absolute values and sign flags, clear remainder and counter, go to BUSY.
  - The capture edge is T0. Operands are sampled only at T0; later changes are ignored.
- BUSY, one iteration per edge:
  - rem' = {rem[WIDTH-1:0], dvd[MSB]}, then dvd shifts left.
  - If rem' >= |divider|: rem' -= |divider| and the quotient bit = 1; otherwise the quotient bit = 0.
  - counter increments each iteration.
  - The iteration with counter==WIDTH-1 (edge T32) also writes result_o with sign correction applied: quotient negated if neg_q, remainder negated if neg_r. It sets success_o=1 and moves to DONE.
  - Latency: success_o is first high after edge T32, i.e. 32 clocks after capture.
- DONE:
  - result_o and success_o hold while start_i=1.
  - When start_i=0 is sampled: go to IDLE, success_o=0, result_o=0.
- Abort:
  - start_i=0 sampled in BUSY means the request was withdrawn. Next edge goes to IDLE with success_o=0 and result_o=0.
  - annul_i=1 in any state gives the same result on the next edge, and overrides a simultaneous start_i.
- Arithmetic:
  - Absolute value uses WIDTH-bit two's-complement negate.
  - 0x80000000 / 0xFFFFFFFF signed wraps to q=0x80000000, r=0. No trap is raised; the overflow exception is not generated here.
  - Remainder carries the dividend's sign; quotient truncates toward zero.
- Back-to-back: a new request needs one IDLE cycle after DONE; start_i must be low for at least one sampled edge between requests.
- busy_o=1 exactly in BUSY. success_o and busy_o are never both high.

Decomposition:
- defines.v gains the state encodings DIV_IDLE=2'b00, DIV_BUSY=2'b01, DIV_DONE=2'b10.
- defines.v also gains DIV_RESULT_ZERO (64'b0), so EX and div_unit share the names.
- No sub-module is needed. The single iteration step (compare/subtract/shift) may be a local function.
- Instantiated beside EX; its signed/dividend/divider/start outputs connect to the matching inputs here, and result_o/success_o feed EX's divide-result inputs.

Test Plan:
- DIVU, 0xFFFFFFFF / 0x00000010, start held -> success_o high 32 clocks after capture; result_o={0x0000000F, 0x0FFFFFFF}; drop start -> success_o=0 next edge.
- DIV, 7 / -2 (0xFFFFFFFE) -> quotient 0xFFFFFFFD, remainder 0x00000001. Then -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV, 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 at the 32-cycle latency; no X values.
- Divide by zero (any dividend, divider 0) -> success_o=1 one edge after capture, result_o=0.
- annul_i pulsed at BUSY iteration 10 -> IDLE next edge, success_o stays 0. A fresh request then completes correctly with the full 32-cycle latency.
- rst driven low asynchronously mid-BUSY -> all outputs 0 immediately without a clock edge. start_i toggled in DONE with one idle cycle between -> two correct back-to-back results.
